uart_tx_param: RTL and testbench

Parametrised next-generation UART transmitter for the low-power multi-clock system. It replaces the fixed 8-bit transmitter with a configurable one. Data width, runtime data length, parity mode and 1/2 stop bits are selectable, and each word carries its own configuration. Input uses a valid/ready handshake with a one-entry holding register, so consecutive frames go out with no idle gap. Bit timing comes from an external baud-tick enable (bit_en) generated in the same clock domain.

---
 rtl/uart_tx_pkg.sv | 53 +++++
 rtl/uart_tx_hold_reg.sv | 67 ++++++
 rtl/uart_tx_param.sv | 159 +++++++++++++++
 tb/tb_uart_tx_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and helpers for the parametrised UART transmitter
//
// Purpose: FSM state encoding, parity-type constants, data-length resolution
// and masked parity used by uart_tx_hold_reg and uart_tx_param.
// Ports: none (package).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Helpers operate on the widest legal frame; callers zero-extend.
  localparam int MAX_WIDTH = 16;
  localparam int MAX_LEN_W = 5;

  // A length of zero or beyond the configured width means "full width".
  function automatic logic [MAX_LEN_W-1:0] resolve_len(
    input logic [MAX_LEN_W-1:0] len,
    input int unsigned          width
  );
    logic [MAX_LEN_W-1:0] w;
    w = MAX_LEN_W'(width);
    if (len == '0 || len > w) begin
      return w;
    end
    return len;
  endfunction

  // Parity over the low len bits only; seeding with par_type turns the
  // even XOR into odd parity for free.
  function automatic logic masked_parity(
    input logic [MAX_WIDTH-1:0] data,
    input logic [MAX_LEN_W-1:0] len,
    input logic                 par_type
  );
    logic acc;
    acc = par_type;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < int'(len)) begin
        acc = acc ^ data[i];
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_tx_hold_reg.sv
// rtl/uart_tx_hold_reg.sv - one-entry holding register with per-word config capture
//
// Purpose: accepts one word plus its frame configuration over a valid/ready
// handshake and keeps it until the transmitter FSM takes it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data/in_valid    incoming payload and its valid
//   in_ready            register empty, a transfer happens on in_valid & in_ready
//   cfg_*               frame configuration captured with the payload
//   take                FSM consumes the held word this edge
//   full                a word is held
//   hold_*              held payload, resolved length, parity enable/bit, stop2
module uart_tx_hold_reg
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_type,
  input  logic                  cfg_stop2,
  input  logic                  take,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] hold_data,
  output logic [LEN_W-1:0]      hold_len,
  output logic                  hold_par_en,
  output logic                  hold_par_bit,
  output logic                  hold_stop2
);

  logic                 push;
  logic [MAX_LEN_W-1:0] len_res;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign len_res  = resolve_len(MAX_LEN_W'(cfg_len), DATA_WIDTH);

  // A push can only happen while empty and a take only while full, so the
  // two never collide on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      full         <= 1'b0;
      hold_data    <= '0;
      hold_len     <= '0;
      hold_par_en  <= 1'b0;
      hold_par_bit <= 1'b0;
      hold_stop2   <= 1'b0;
    end else if (push) begin
      full         <= 1'b1;
      hold_data    <= in_data;
      hold_len     <= LEN_W'(len_res);
      hold_par_en  <= cfg_par_en;
      // Parity is resolved at capture so the FSM just replays one bit.
      hold_par_bit <= masked_parity(MAX_WIDTH'(in_data), len_res, cfg_par_type);
      hold_stop2   <= cfg_stop2;
    end else if (take) begin
      full         <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with per-word frame config
//
// Purpose: serialises start, LSB-first data, optional parity and 1/2 stop
// bits, advancing only on bit_en ticks; back-to-back frames have no idle gap.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bit_en              baud tick enable
//   in_data/in_valid    payload handshake, in_ready = holding register empty
//   cfg_len             data bits (0 or > DATA_WIDTH selects DATA_WIDTH)
//   cfg_par_en/type     parity enable, 0 even / 1 odd
//   cfg_stop2           two stop bits when set
//   tx_out              registered serial line
//   busy                frame in progress
//   frame_done          one-cycle pulse after the last stop bit
module uart_tx_param
  import uart_tx_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   LEN_W      = $clog2(DATA_WIDTH + 1),
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_type,
  input  logic                  cfg_stop2,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [LEN_W-1:0]      bit_cnt;
  logic [LEN_W-1:0]      frame_len;
  logic                  frame_par_en;
  logic                  frame_par_bit;
  logic                  frame_stop2;
  logic                  stop_cnt;

  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [LEN_W-1:0]      hold_len;
  logic                  hold_par_en;
  logic                  hold_par_bit;
  logic                  hold_stop2;

  logic                  last_stop;
  logic                  take;

  uart_tx_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_W      (LEN_W)
  ) u_hold (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cfg_len      (cfg_len),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_type (cfg_par_type),
    .cfg_stop2    (cfg_stop2),
    .take         (take),
    .full         (hold_full),
    .hold_data    (hold_data),
    .hold_len     (hold_len),
    .hold_par_en  (hold_par_en),
    .hold_par_bit (hold_par_bit),
    .hold_stop2   (hold_stop2)
  );

  // stop_cnt counts ticks already spent in STOP; the final one is reached
  // on the first tick for one stop bit and the second for two.
  assign last_stop = (state == STOP) && (stop_cnt == frame_stop2);
  assign take      = bit_en && hold_full && ((state == IDLE) || last_stop);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tx_out        <= IDLE_LEVEL;
      frame_done    <= 1'b0;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      frame_len     <= '0;
      frame_par_en  <= 1'b0;
      frame_par_bit <= 1'b0;
      frame_stop2   <= 1'b0;
      stop_cnt      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (bit_en) begin
        unique case (state)
          IDLE: begin
            // Frame start is handled by the take path below.
          end
          START: begin
            tx_out    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= LEN_W'(1);
            state     <= DATA;
          end
          DATA: begin
            if (bit_cnt < frame_len) begin
              tx_out    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 1'b1;
            end else if (frame_par_en) begin
              tx_out <= frame_par_bit;
              state  <= PARITY;
            end else begin
              tx_out   <= IDLE_LEVEL;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end
          PARITY: begin
            tx_out   <= IDLE_LEVEL;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
          STOP: begin
            if (last_stop) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
          default: begin
            tx_out <= IDLE_LEVEL;
            state  <= IDLE;
          end
        endcase

        // Loading a held word overrides the IDLE return above, which gives
        // back-to-back frames straight out of the last stop bit.
        if (take) begin
          tx_out        <= ~IDLE_LEVEL;
          shift_reg     <= hold_data;
          frame_len     <= hold_len;
          frame_par_en  <= hold_par_en;
          frame_par_bit <= hold_par_bit;
          frame_stop2   <= hold_stop2;
          bit_cnt       <= '0;
          stop_cnt      <= 1'b0;
          state         <= START;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - scoreboard bench for uart_tx_param
module tb_uart_tx_param;

  localparam int DW = 8;
  localparam int LW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bit_en = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_par_en = 1'b0;
  logic          cfg_par_type = 1'b0;
  logic          cfg_stop2 = 1'b0;
  logic          tx_out;
  logic          busy;
  logic          frame_done;

  int   vectors = 0;
  int   errors = 0;
  logic exp_q[$];
  int   len_q[$];
  int   mon_bits = 0;
  bit   mon_en = 1'b0;
  bit   gate_mode = 1'b0;
  logic tick_seen = 1'b0;
  logic rst_seen = 1'b1;
  logic prev_tx = 1'b1;
  logic prev_busy = 1'b0;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_WIDTH (DW),
    .LEN_W      (LW),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_en       (bit_en),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cfg_len      (cfg_len),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_type (cfg_par_type),
    .cfg_stop2    (cfg_stop2),
    .tx_out       (tx_out),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  // What the DUT saw on the last rising edge.
  always @(posedge clk) begin
    tick_seen <= bit_en;
    rst_seen  <= rst;
  end

  // Baud tick: always on, or one edge in four.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (gate_mode) begin
        ph     = (ph + 1) % 4;
        bit_en = (ph == 0);
      end else begin
        ph     = 0;
        bit_en = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every tick edge while busy puts one line bit on tx_out.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst_seen) begin
        if (frame_done) begin
          if (len_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_frame_done: pulse with no frame queued at %0t", $time);
          end else begin
            check("frame_ticks", mon_bits, len_q.pop_front());
          end
          mon_bits = 0;
        end
        if (tick_seen) begin
          if (busy) begin
            if (exp_q.size() == 0) begin
              vectors++;
              errors++;
              $display("FAIL unexpected_bit: line bit %b with nothing queued at %0t", tx_out, $time);
            end else begin
              check("line_bit", tx_out, exp_q.pop_front());
            end
            mon_bits++;
          end
        end else begin
          check("hold_on_no_tick", {busy, tx_out, frame_done}, {prev_busy, prev_tx, 1'b0});
        end
      end
      prev_tx   = tx_out;
      prev_busy = busy;
    end
  end

  task automatic expect_frame(input string s);
    int n;
    n = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "0" || s[i] == "1") begin
        exp_q.push_back(s[i] == "1");
        n++;
      end
    end
    len_q.push_back(n);
  endtask

  task automatic send(input logic [DW-1:0] d, input int len, input logic pe, input logic pt,
                      input logic s2, input string bits);
    int t;
    in_data      = d;
    cfg_len      = LW'(len);
    cfg_par_en   = pe;
    cfg_par_type = pt;
    cfg_stop2    = s2;
    in_valid     = 1'b1;
    t = 0;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles", in_ready, t);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    cfg_len  = '0;
    expect_frame(bits);
    check("in_ready_after_accept", in_ready, 1'b0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0 || len_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_in_time", (t < 2000), 1'b1);
    check("idle_line", tx_out, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    int t;
    int dc;
    repeat (3) @(negedge clk);
    check("rst_tx_out", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    send(8'hA5, 8, 1'b1, 1'b0, 1'b0, "0 10100101 0 1");
    wait_idle();
    send(8'h7F, 7, 1'b1, 1'b1, 1'b1, "0 1111111 0 11");
    wait_idle();
    send(8'hFF, 5, 1'b1, 1'b0, 1'b0, "0 11111 1 1");
    wait_idle();
    send(8'hFF, 0, 1'b1, 1'b0, 1'b0, "0 11111111 0 1");
    wait_idle();
    send(8'h0F, 9, 1'b0, 1'b0, 1'b1, "0 11110000 11");
    wait_idle();

    // Back-to-back frames: busy must stay high until the second frame_done.
    send(8'h81, 8, 1'b0, 1'b0, 1'b0, "0 10000001 1");
    send(8'h3C, 8, 1'b1, 1'b1, 1'b0, "0 00111100 1 1");
    dc = 0;
    t  = 0;
    while (dc < 2 && t < 100) begin
      @(negedge clk);
      t++;
      if (frame_done) dc++;
      if (dc < 2) check("busy_between_frames", busy, 1'b1);
    end
    check("frame_done_pulses", dc, 2);
    wait_idle();

    // bit_en one edge in four.
    gate_mode = 1'b1;
    send(8'h5A, 6, 1'b1, 1'b0, 1'b1, "0 010110 1 11");
    wait_idle();
    gate_mode = 1'b0;
    repeat (4) @(negedge clk);

    // Reset mid-frame with a second word held.
    send(8'hC3, 8, 1'b0, 1'b0, 1'b0, "0 11000011 1");
    send(8'h99, 8, 1'b0, 1'b0, 1'b0, "0 10011001 1");
    t = 0;
    while (mon_bits < 5 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reached_data_bit3", mon_bits, 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx_out", tx_out, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_frame_done", frame_done, 1'b0);
    exp_q.delete();
    len_q.delete();
    mon_bits = 0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_tx_out", tx_out, 1'b1);
    check("post_rst_no_pending", exp_q.size() + len_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
